// File: rtl/cla8_seq_pkg.sv
// rtl/cla8_seq_pkg.sv - shared constants for the byte-serial CLA adder
// Purpose: FSM state encodings and datapath byte width used by cla8,
//          cla8_seq_adder_if and cla8_seq_adder.
// Ports:   none (package).
package cla8_seq_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/cla8_seq_adder_if.sv
// rtl/cla8_seq_adder_if.sv - host handshake/operand bus for cla8_seq_adder
// Purpose: groups start/operand inputs and busy/done/result outputs.
//          Optional ovf signal present when CLA8_SEQ_ADDER_OVF_EN is defined.
// Ports:   start, op_sub, a, b, ci (host -> adder);
//          busy, done, s, co [, ovf] (adder -> host).
//          Modports: master (host side), slave (adder side).
interface cla8_seq_adder_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
`ifdef CLA8_SEQ_ADDER_OVF_EN
  logic         ovf;

  modport master (
    output start, op_sub, a, b, ci,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, op_sub, a, b, ci,
    output busy, done, s, co, ovf
  );
`else
  modport master (
    output start, op_sub, a, b, ci,
    input  busy, done, s, co
  );

  modport slave (
    input  start, op_sub, a, b, ci,
    output busy, done, s, co
  );
`endif

endinterface

// File: rtl/cla8_seq_adder_cla8.sv
// rtl/cla8_seq_adder_cla8.sv - 8-bit carry-lookahead adder (cla8)
// Purpose: purely combinational 8-bit adder; every carry is formed directly
//          from generate/propagate terms rather than rippled.
// Ports:   a, b (8-bit addends), ci (carry in) -> s (8-bit sum), co (carry out).
module cla8
  import cla8_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  logic [BYTE_W-1:0] g;
  logic [BYTE_W-1:0] p;
  logic [BYTE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i] = OR over j<i of (g[j] & p[j+1..i-1]) | (ci & p[0..i-1])
  always_comb begin
    logic term;
    c    = '0;
    term = 1'b0;
    c[0] = ci;
    for (int i = 1; i <= BYTE_W; i++) begin
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        c[i] = c[i] | term;
      end
      term = ci;
      for (int k = 0; k < i; k++) begin
        term = term & p[k];
      end
      c[i] = c[i] | term;
    end
  end

  assign s  = p ^ c[BYTE_W-1:0];
  assign co = c[BYTE_W];

endmodule

// File: rtl/cla8_seq_adder.sv
// rtl/cla8_seq_adder.sv - byte-serial NBYTES-wide add/subtract around one cla8
// Purpose: accepts a start in IDLE, then feeds one operand byte per clock
//          (LSB first) through a single cla8, chaining the carry through a
//          register, and pulses done for one cycle when the result is ready.
//          Define CLA8_SEQ_ADDER_OVF_EN to add the signed-overflow flag (ovf).
// Ports:   clk   - rising-edge clock
//          reset - asynchronous active-high reset
//          bus   - cla8_seq_adder_if.slave (start/op_sub/a/b/ci in,
//                  busy/done/s/co[/ovf] out)
module cla8_seq_adder
  import cla8_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input logic                 clk,
  input logic                 reset,
  cla8_seq_adder_if.slave     bus
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              carry;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;   // already inverted for subtract
  logic [W-1:0]      s_reg;
  logic              co_reg;

  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] sum_byte;
  logic              sum_co;
  logic              last;

  assign a_byte = a_reg[cnt*BYTE_W +: BYTE_W];
  assign b_byte = b_reg[cnt*BYTE_W +: BYTE_W];
  assign last   = (cnt == LAST_CNT);

  cla8 u_cla8 (
    .a  (a_byte),
    .b  (b_byte),
    .ci (carry),
    .s  (sum_byte),
    .co (sum_co)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      s_reg  <= '0;
      co_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_reg  <= bus.a;
            b_reg  <= bus.op_sub ? ~bus.b : bus.b;
            // Subtract is a + ~b + 1, so the "+1" enters as the initial carry.
            carry  <= bus.op_sub | bus.ci;
            cnt    <= '0;
            s_reg  <= '0;
            co_reg <= 1'b0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          s_reg[cnt*BYTE_W +: BYTE_W] <= sum_byte;
          carry <= sum_co;
          if (last) begin
            // Park the counter at 0 so it never steps past NBYTES-1 when
            // NBYTES is not a power of two.
            cnt    <= '0;
            co_reg <= sum_co;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CLA8_SEQ_ADDER_OVF_EN
  logic ovf_reg;

  // Signed overflow: operands of equal sign produce a sum of the other sign.
  // Evaluated on the top byte only, using the effective (possibly inverted) B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_reg <= 1'b0;
    end else if (state == ST_IDLE && bus.start) begin
      ovf_reg <= 1'b0;
    end else if (state == ST_RUN && last) begin
      ovf_reg <= (a_byte[BYTE_W-1] == b_byte[BYTE_W-1]) &&
                 (sum_byte[BYTE_W-1] != a_byte[BYTE_W-1]);
    end
  end

  assign bus.ovf = ovf_reg;
`endif

  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.s    = s_reg;
  assign bus.co   = co_reg;

endmodule
